sram_arbiter2: RTL and testbench

- Shares one `sync_sram` instance between two requesters, m0 and m1.
- Arbitration is round-robin; each requester has a req/gnt handshake.
- The block sequences the SRAM's single-cycle command and 1-cycle read latency, and returns read data to the owning requester with an rvalid pulse.
- Sits between client logic (e.g. DMA, CPU-side port) and the SRAM macro.

---
 rtl/sram_arb_pkg.sv | 14 +
 rtl/sram_rr_arb2.sv | 24 ++
 rtl/sync_sram.sv | 25 ++
 rtl/sram_arbiter2.sv | 115 +++++++++++
 tb/tb_sram_arbiter2.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: FSM state
// encodings and requester identifiers.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

endpackage

// File: rtl/sram_rr_arb2.sv
// Combinational two-way round-robin picker.
// Ports: req[1:0], last in; gnt[1:0], winner out.
module sram_rr_arb2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       winner
);

    always_comb begin
        winner = REQ_M0;
        unique case (req)
            2'b01:   winner = REQ_M0;
            2'b10:   winner = REQ_M1;
            // contention: whoever did not win last time
            2'b11:   winner = ~last;
            default: winner = REQ_M0;
        endcase
        gnt = {winner, ~winner} & {2{|req}};
    end

endmodule

// File: rtl/sync_sram.sv
// Single-port synchronous SRAM model: write on we_n low at the
// rising edge, registered read data one cycle after addr.
// Ports: clk, we_n, addr, din in; dout out.
module sync_sram #(
    parameter int addr_width = 8,
    parameter int word_depth = 256,
    parameter int word_width = 8
) (
    input  logic                  clk,
    input  logic                  we_n,
    input  logic [addr_width-1:0] addr,
    input  logic [word_width-1:0] din,
    output logic [word_width-1:0] dout
);

    logic [word_width-1:0] mem [word_depth];

    always_ff @(posedge clk) begin
        if (!we_n) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/sram_arbiter2.sv
// Shares one sync_sram between requesters m0 and m1 with
// round-robin grant; sequences command and 1-cycle read latency.
// Ports: clk, rst; m0_*/m1_* req/wr/addr/wdata in, gnt/rvalid/
// rdata out; sram_addr/din/we_n out, sram_dout in; busy out.
module sram_arbiter2
    import sram_arb_pkg::*;
#(
    parameter int addr_width = 8,
    parameter int word_depth = 256,
    parameter int word_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_wr,
    input  logic [addr_width-1:0] m0_addr,
    input  logic [word_width-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [word_width-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_wr,
    input  logic [addr_width-1:0] m1_addr,
    input  logic [word_width-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [word_width-1:0] m1_rdata,
    output logic [addr_width-1:0] sram_addr,
    output logic [word_width-1:0] sram_din,
    output logic                  sram_we_n,
    input  logic [word_width-1:0] sram_dout,
    output logic                  busy
);

    if (2 ** addr_width < word_depth) begin : g_bad_depth
        $error("addr_width too small for word_depth");
    end

    state_t                state_q, state_d;
    logic                  owner_q, last_q, wr_q;
    logic [addr_width-1:0] addr_q;
    logic [word_width-1:0] din_q, rd0_q, rd1_q;
    logic [1:0]            arb_gnt;
    logic                  winner;
    logic                  take;

    sram_rr_arb2 u_arb (
        .req    ({m1_req, m0_req}),
        .last   (last_q),
        .gnt    (arb_gnt),
        .winner (winner)
    );

    // a grant is only ever issued from IDLE and never under reset
    assign take = (state_q == IDLE) && !rst
                  && (m0_req || m1_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (m0_req || m1_req) state_d = CMD;
            CMD:     state_d = wr_q ? IDLE : DATA;
            DATA:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= REQ_M0;
            last_q  <= REQ_M1;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            if (take) begin
                owner_q <= winner;
                last_q  <= winner;
                wr_q    <= winner ? m1_wr : m0_wr;
                addr_q  <= winner ? m1_addr : m0_addr;
                din_q   <= winner ? m1_wdata : m0_wdata;
            end
            if (state_q == DATA) begin
                if (owner_q == REQ_M1) rd1_q <= sram_dout;
                else                   rd0_q <= sram_dout;
            end
        end
    end

    always_comb begin
        m0_gnt    = take && arb_gnt[0];
        m1_gnt    = take && arb_gnt[1];
        m0_rvalid = (state_q == DATA) && !rst
                    && (owner_q == REQ_M0);
        m1_rvalid = (state_q == DATA) && !rst
                    && (owner_q == REQ_M1);
        m0_rdata  = m0_rvalid ? sram_dout : rd0_q;
        m1_rdata  = m1_rvalid ? sram_dout : rd1_q;
        sram_addr = addr_q;
        sram_din  = din_q;
        sram_we_n = !((state_q == CMD) && wr_q && !rst);
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_sram_arbiter2.sv
// Directed checks for sram_arbiter2 against a sync_sram model:
// per-cycle vector table plus a back-to-back read sequence.
module tb_sram_arbiter2;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_req, m0_wr, m1_req, m1_wr;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [7:0] m0_rdata, m1_rdata;
    logic [7:0] sram_addr, sram_din, sram_dout;
    logic       sram_we_n, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_arbiter2 #(
        .addr_width (8),
        .word_depth (256),
        .word_width (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_wr     (m0_wr),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_wr     (m1_wr),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_we_n (sram_we_n),
        .sram_dout (sram_dout),
        .busy      (busy)
    );

    sync_sram #(
        .addr_width (8),
        .word_depth (256),
        .word_width (8)
    ) u_sram (
        .clk  (clk),
        .we_n (sram_we_n),
        .addr (sram_addr),
        .din  (sram_din),
        .dout (sram_dout)
    );

    typedef struct {
        logic       rst;
        logic       r0, w0;
        logic [7:0] a0, d0;
        logic       r1, w1;
        logic [7:0] a1, d1;
        logic       g0, g1, v0, v1;
        logic [7:0] rd;
        logic       we_n, busy;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic rs,
        input logic r0, input logic w0,
        input logic [7:0] a0, input logic [7:0] d0,
        input logic r1, input logic w1,
        input logic [7:0] a1, input logic [7:0] d1,
        input logic g0, input logic g1,
        input logic v0, input logic v1,
        input logic [7:0] rd,
        input logic we, input logic bz);
        vec_t v;
        v.rst = rs;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
        v.rd = rd; v.we_n = we; v.busy = bz;
        return v;
    endfunction

    task automatic chk(input string nm, input int got,
                       input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst      = v.rst;
        m0_req   = v.r0; m0_wr = v.w0;
        m0_addr  = v.a0; m0_wdata = v.d0;
        m1_req   = v.r1; m1_wr = v.w1;
        m1_addr  = v.a1; m1_wdata = v.d1;
    endtask

    initial begin
        logic [7:0] raddr [4];
        logic [7:0] rdat  [4];
        vec_t v;
        string tag;

        // reset / m0 write then read back
        vq.push_back(mk(1, 1,1,8'h10,8'hA5, 0,0,0,0, 0,0,0,0,0, 1,0));
        vq.push_back(mk(0, 1,1,8'h10,8'hA5, 0,0,0,0, 1,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,1));
        vq.push_back(mk(0, 1,0,8'h10,0, 0,0,0,0, 1,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,1));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,1,0,8'hA5, 1,1));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,0));
        // both writing continuously from reset
        vq.push_back(mk(1, 1,1,8'h01,8'h11, 1,1,8'h02,8'h22, 0,0,0,0,0, 1,0));
        vq.push_back(mk(0, 1,1,8'h01,8'h11, 1,1,8'h02,8'h22, 1,0,0,0,0, 1,0));
        vq.push_back(mk(0, 1,1,8'h01,8'h11, 1,1,8'h02,8'h22, 0,0,0,0,0, 0,1));
        vq.push_back(mk(0, 1,1,8'h01,8'h11, 1,1,8'h02,8'h22, 0,1,0,0,0, 1,0));
        vq.push_back(mk(0, 1,1,8'h01,8'h11, 1,1,8'h02,8'h22, 0,0,0,0,0, 0,1));
        vq.push_back(mk(0, 1,1,8'h01,8'h11, 1,1,8'h02,8'h22, 1,0,0,0,0, 1,0));
        vq.push_back(mk(0, 1,1,8'h01,8'h11, 1,1,8'h02,8'h22, 0,0,0,0,0, 0,1));
        vq.push_back(mk(0, 1,1,8'h01,8'h11, 1,1,8'h02,8'h22, 0,1,0,0,0, 1,0));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,1));
        // reads; m1 waits while m0 read is in flight
        vq.push_back(mk(0, 1,0,8'h01,0, 1,0,8'h02,0, 1,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,0,0,0, 1,0,8'h02,0, 0,0,0,0,0, 1,1));
        vq.push_back(mk(0, 0,0,0,0, 1,0,8'h02,0, 0,0,1,0,8'h11, 1,1));
        vq.push_back(mk(0, 0,0,0,0, 1,0,8'h02,0, 0,1,0,0,0, 1,0));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,1));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,1,8'h22, 1,1));
        // boundary addresses 0xFF and 0x00
        vq.push_back(mk(0, 1,1,8'hFF,8'hFF, 0,0,0,0, 1,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,1));
        vq.push_back(mk(0, 0,0,0,0, 1,0,8'hFF,0, 0,1,0,0,0, 1,0));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,1));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,1,8'hFF, 1,1));
        vq.push_back(mk(0, 0,0,0,0, 1,1,8'h00,8'h3C, 0,1,0,0,0, 1,0));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,1));
        vq.push_back(mk(0, 1,0,8'h00,0, 0,0,0,0, 1,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,1));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,1,0,8'h3C, 1,1));
        // reset aborts m1 write to 0x20
        vq.push_back(mk(0, 1,1,8'h20,8'h33, 0,0,0,0, 1,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,1));
        vq.push_back(mk(0, 0,0,0,0, 1,1,8'h20,8'h5A, 0,1,0,0,0, 1,0));
        vq.push_back(mk(1, 1,0,8'h20,0, 1,0,8'h02,0, 0,0,0,0,0, 1,1));
        vq.push_back(mk(0, 1,0,8'h20,0, 1,0,8'h02,0, 1,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,0,0,0, 1,0,8'h02,0, 0,0,0,0,0, 1,1));
        vq.push_back(mk(0, 0,0,0,0, 1,0,8'h02,0, 0,0,1,0,8'h33, 1,1));
        vq.push_back(mk(0, 0,0,0,0, 1,0,8'h02,0, 0,1,0,0,0, 1,0));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,1));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,1,8'h22, 1,1));
        // reset in DATA of a read suppresses rvalid
        vq.push_back(mk(0, 1,0,8'h10,0, 0,0,0,0, 1,0,0,0,0, 1,0));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,1));
        vq.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,1));
        vq.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,0));

        drive(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,0));
        repeat (2) @(posedge clk);

        foreach (vq[i]) begin
            v = vq[i];
            @(negedge clk);
            drive(v);
            #1;
            tag = $sformatf("v%0d", i);
            chk({tag, ".m0_gnt"}, m0_gnt, v.g0);
            chk({tag, ".m1_gnt"}, m1_gnt, v.g1);
            chk({tag, ".m0_rvalid"}, m0_rvalid, v.v0);
            chk({tag, ".m1_rvalid"}, m1_rvalid, v.v1);
            chk({tag, ".we_n"}, sram_we_n, v.we_n);
            chk({tag, ".busy"}, busy, v.busy);
            if (v.v0) chk({tag, ".m0_rdata"}, m0_rdata, v.rd);
            if (v.v1) chk({tag, ".m1_rdata"}, m1_rdata, v.rd);
        end

        // m1 alone: four back-to-back reads, one per 3 cycles
        raddr[0] = 8'h02; rdat[0] = 8'h22;
        raddr[1] = 8'hFF; rdat[1] = 8'hFF;
        raddr[2] = 8'h00; rdat[2] = 8'h3C;
        raddr[3] = 8'h20; rdat[3] = 8'h33;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rst     = 1'b0;
            m0_req  = 1'b0;
            m1_req  = (c < 10);
            m1_wr   = 1'b0;
            m1_addr = raddr[(c < 10) ? c / 3 : 3];
            #1;
            tag = $sformatf("rr%0d", c);
            chk({tag, ".m1_gnt"}, m1_gnt, (c % 3 == 0));
            chk({tag, ".m1_rvalid"}, m1_rvalid, (c % 3 == 2));
            chk({tag, ".m0_gnt"}, m0_gnt, 0);
            if (c % 3 == 2)
                chk({tag, ".m1_rdata"}, m1_rdata, rdat[c / 3]);
            else if (c >= 3)
                chk({tag, ".m1_hold"}, m1_rdata, rdat[c / 3 - 1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
